// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt unit (M stage).
// Holds SR, Cause and EPC, serves mfc0/mtc0, raises Req for interrupts and
// exceptions, and supplies EPC for eret. Req and Dout are combinational by
// design: the pipeline needs them in the same cycle as the M-stage inputs.
module cp0_unit #(
   parameter logic [31:0] PRID       = 32'h2025_0001,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] Dout,
   output logic [31:0] EPCOut,
   output logic        Req,
   output logic [31:0] HandlerPC
);

   // SR fields
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   // Cause fields
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   // EPC
   logic [31:0] epc_q, epc_d;

   logic [31:0] sr_s;
   logic [31:0] cause_s;
   logic        int_req_s;
   logic        exc_req_s;

   assign sr_s    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
   assign cause_s = {bd_q, 15'h0000, ip_q, 3'b000, exccode_q, 2'b00};

   // Request generation: nothing is taken while already inside a handler.
   always_comb begin
      int_req_s = (|(HWInt & im_q)) & ie_q & ~exl_q;
      exc_req_s = (ExcCodeIn != 5'd0) & ~exl_q;
   end

   assign Req       = int_req_s | exc_req_s;
   assign EPCOut    = epc_q;
   assign HandlerPC = HANDLER_PC;

   // mfc0 read mux; reads registered state only, no same-cycle mtc0 bypass.
   always_comb begin
      Dout = 32'h0000_0000;
      case (A1)
         5'd12:   Dout = sr_s;
         5'd13:   Dout = cause_s;
         5'd14:   Dout = epc_q;
         5'd15:   Dout = PRID;
         default: Dout = 32'h0000_0000;
      endcase
   end

   // Next-state: Req beats mtc0/eret (that instruction is being flushed);
   // eret beats an mtc0 on the EXL bit only.
   always_comb begin
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      ip_d      = HWInt;
      if (Req) begin
         exl_d     = 1'b1;
         bd_d      = BDIn;
         exccode_d = int_req_s ? 5'd0 : ExcCodeIn;
         epc_d     = BDIn ? (VPC - 32'd4) : VPC;
      end else begin
         if (WE) begin
            case (A2)
               5'd12: begin
                  im_d  = Din[15:10];
                  exl_d = Din[1];
                  ie_d  = Din[0];
               end
               5'd14:   epc_d = Din;
               default: epc_d = epc_q;
            endcase
         end else begin
            epc_d = epc_q;
         end
         if (EXLClr) begin
            exl_d = 1'b0;
         end else begin
            exl_d = exl_d;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q      <= 6'd0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= 6'd0;
         exccode_q <= 5'd0;
         epc_q     <= 32'h0000_0000;
      end else begin
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: a cycle-by-cycle vector table plus a scoreboard
// queue of expected outputs, and a short hand-written sequence at the end.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2, ExcCodeIn;
   logic [31:0] Din, VPC;
   logic        WE, BDIn, EXLClr;
   logic [5:0]  HWInt;
   logic [31:0] Dout, EPCOut, HandlerPC;
   logic        Req;

   cp0_unit dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
      .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
      .EXLClr(EXLClr), .Dout(Dout), .EPCOut(EPCOut), .Req(Req),
      .HandlerPC(HandlerPC)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] din;
      logic        we;
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        clr;
      logic [31:0] e_dout;
      logic        e_req;
      logic [31:0] e_epc;
   } vec_t;

   typedef struct {
      logic [31:0] dout;
      logic        req;
      logic [31:0] epc;
   } exp_t;

   localparam int NV = 31;
   vec_t tbl [NV];
   exp_t sb_q [$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(logic rst, logic [4:0] a1, logic [4:0] a2,
                               logic [31:0] din, logic we, logic [31:0] vpc,
                               logic bd, logic [4:0] exc, logic [5:0] hw,
                               logic clr, logic [31:0] e_dout, logic e_req,
                               logic [31:0] e_epc);
      vec_t v;
      v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we;
      v.vpc = vpc; v.bd = bd; v.exc = exc; v.hw = hw; v.clr = clr;
      v.e_dout = e_dout; v.e_req = e_req; v.e_epc = e_epc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset = v.rst; A1 = v.a1; A2 = v.a2; Din = v.din; WE = v.we;
      VPC = v.vpc; BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw;
      EXLClr = v.clr;
   endtask

   task automatic check(input int idx);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty vec=%0d", idx);
      end else begin
         e = sb_q.pop_front();
         n_vec++;
         if (Dout !== e.dout) begin
            n_fail++;
            $display("FAIL dout vec=%0d got=%h exp=%h", idx, Dout, e.dout);
         end
         if (Req !== e.req) begin
            n_fail++;
            $display("FAIL req vec=%0d got=%b exp=%b", idx, Req, e.req);
         end
         if (EPCOut !== e.epc) begin
            n_fail++;
            $display("FAIL epcout vec=%0d got=%h exp=%h", idx, EPCOut, e.epc);
         end
      end
   endtask

   // Apply one vector away from the active edge and check it before the edge.
   task automatic apply(input vec_t v, input int idx);
      exp_t e;
      @(negedge clk);
      drive(v);
      e.dout = v.e_dout; e.req = v.e_req; e.epc = v.e_epc;
      sb_q.push_back(e);
      #1;
      check(idx);
   endtask

   initial begin
      //             rst a1     a2     din            we   vpc            bd   exc    hw       clr   dout           req  epc
      tbl[0]  = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[1]  = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[2]  = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[3]  = mk(1'b0, 5'd15, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h01, 1'b0, 32'h2025_0001, 1'b0, 32'h0);
      tbl[4]  = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0000_0400, 1'b0, 32'h0);
      tbl[5]  = mk(1'b0, 5'd5,  5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      // mtc0 SR = IM0|IE; no same-cycle bypass
      tbl[6]  = mk(1'b0, 5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      // T0 interrupt taken
      tbl[7]  = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3010, 1'b0, 5'd0, 6'h01, 1'b0, 32'h0000_0401, 1'b1, 32'h0);
      tbl[8]  = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0000_0400, 1'b0, 32'h0000_3010);
      tbl[9]  = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0000_0403, 1'b0, 32'h0000_3010);
      tbl[10] = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3010);
      // eret with mtc0 SR=0 in the same cycle
      tbl[11] = mk(1'b0, 5'd12, 5'd12, 32'h0,         1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 32'h0000_0403, 1'b0, 32'h0000_3010);
      // delay-slot AdEL with IE=0
      tbl[12] = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3024, 1'b1, 5'd4, 6'h00, 1'b0, 32'h0,         1'b1, 32'h0000_3010);
      tbl[13] = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h8000_0010, 1'b0, 32'h0000_3020);
      tbl[14] = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0000_3020, 1'b0, 32'h0000_3020);
      // mtc0 SR with EXL=1 coincident with eret: EXL ends 0
      tbl[15] = mk(1'b0, 5'd12, 5'd12, 32'h0000_0803, 1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 32'h0000_0002, 1'b0, 32'h0000_3020);
      // interrupt + exception + mtc0 EPC all at once
      tbl[16] = mk(1'b0, 5'd12, 5'd14, 32'hDEAD_BEEF, 1'b1, 32'h0000_3100, 1'b0, 5'd10, 6'h02, 1'b0, 32'h0000_0801, 1'b1, 32'h0000_3020);
      // inside handler: everything masked, IP tracks
      tbl[17] = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd12, 6'h3F, 1'b0, 32'h0000_0800, 1'b0, 32'h0000_3100);
      tbl[18] = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd12, 6'h3F, 1'b0, 32'h0000_FC00, 1'b0, 32'h0000_3100);
      tbl[19] = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h3F, 1'b1, 32'h0000_0803, 1'b0, 32'h0000_3100);
      // level interrupt re-asserts after eret
      tbl[20] = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3200, 1'b0, 5'd0, 6'h3F, 1'b0, 32'h0000_0801, 1'b1, 32'h0000_3100);
      // reset mid-handler
      tbl[21] = mk(1'b1, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h3F, 1'b0, 32'h0000_3200, 1'b0, 32'h0000_3200);
      tbl[22] = mk(1'b0, 5'd12, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[23] = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[24] = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      // mtc0 to Cause ignored, IP still tracks
      tbl[25] = mk(1'b0, 5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b0, 5'd0,  6'h04, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[26] = mk(1'b0, 5'd13, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0000_1000, 1'b0, 32'h0);
      // mtc0 EPC visible next cycle
      tbl[27] = mk(1'b0, 5'd14, 5'd14, 32'h1234_5678, 1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h0,         1'b0, 32'h0);
      tbl[28] = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678);
      // delay-slot exception at VPC=0 wraps
      tbl[29] = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b1, 5'd4,  6'h00, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678);
      tbl[30] = mk(1'b0, 5'd14, 5'd0,  32'h0,         1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);

      drive(mk(1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0));
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i], i);
      end

      // Hand sequence: eret and mtc0 SR coincident with Req are discarded.
      // State now: EXL=1, SR IM=0 IE=0. Clear EXL, then raise an exception
      // together with an mtc0 that would set IE and an eret.
      apply(mk(1'b0, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1,
               32'h0000_0002, 1'b0, 32'hFFFF_FFFC), 100);
      apply(mk(1'b0, 5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'h0000_5000, 1'b0, 5'd8, 6'h00, 1'b1,
               32'h0, 1'b1, 32'hFFFF_FFFC), 101);
      apply(mk(1'b0, 5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd8, 6'h00, 1'b0,
               32'h0000_0002, 1'b0, 32'h0000_5000), 102);
      apply(mk(1'b0, 5'd13, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0,
               32'h0000_0020, 1'b0, 32'h0000_5000), 103);

      n_vec++;
      if (HandlerPC !== 32'h0000_4180) begin
         n_fail++;
         $display("FAIL handler_pc got=%h exp=%h", HandlerPC, 32'h0000_4180);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
